// File: rtl/fc_argmax.sv
// Argmax classifier stage: snapshots a vector of float32 activations on start and
// scans one node per cycle, reporting the index and value of the largest element.
module fc_argmax #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_NODES = 32,
  parameter int INDEX_WIDTH  = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] input_fc,
  output logic                             busy,
  output logic                             done,
  output logic [INDEX_WIDTH-1:0]           class_index,
  output logic [DATA_WIDTH-1:0]            max_value
);

  // state | meaning
  // IDLE  | waiting for start; results held
  // SCAN  | walking snapshot nodes 1..OUTPUT_NODES-1 against the running best
  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(OUTPUT_NODES - 1);
  localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   snap_q [OUTPUT_NODES];
  logic                    capture;
  logic [INDEX_WIDTH-1:0]  cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0]   best_val_q, best_val_d;
  logic                    done_q, done_d;
  logic [INDEX_WIDTH-1:0]  class_q, class_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;

  logic [DATA_WIDTH-1:0]   cand;
  logic [INDEX_WIDTH-1:0]  next_idx;
  logic [DATA_WIDTH-1:0]   next_val;

  // Monotonic unsigned key: flipping the sign bit of positives and all bits of
  // negatives makes plain unsigned compare follow float ordering.
  function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
    if (v[DATA_WIDTH-1])
      return ~v;
    else
      return v ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    done_d     = 1'b0;
    class_d    = class_q;
    max_d      = max_q;
    capture    = 1'b0;
    cand       = snap_q[cnt_q];
    next_idx   = best_idx_q;
    next_val   = best_val_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          best_idx_d = '0;
          best_val_d = input_fc[DATA_WIDTH-1:0];
          cnt_d      = ONE_IDX;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        // Strict greater-than so ties keep the lower index.
        if (order_key(cand) > order_key(best_val_q)) begin
          next_idx = cnt_q;
          next_val = cand;
        end
        best_idx_d = next_idx;
        best_val_d = next_val;
        cnt_d      = cnt_q + ONE_IDX;
        if (cnt_q == LAST_IDX) begin
          class_d = next_idx;
          max_d   = next_val;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      done_q     <= 1'b0;
      class_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      done_q     <= done_d;
      class_q    <= class_d;
      max_q      <= max_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUTPUT_NODES; i++) snap_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < OUTPUT_NODES; i++) snap_q[i] <= input_fc[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  assign busy        = (state_q == SCAN);
  assign done        = done_q;
  assign class_index = class_q;
  assign max_value   = max_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: stimulus pushes expected results, a monitor
// pops and compares them on every done pulse.
module tb_fc_argmax;
  localparam int DW = 32;
  localparam int N  = 32;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DW*N-1:0]   input_fc = '0;
  logic              busy, done;
  logic [IW-1:0]     class_index;
  logic [DW-1:0]     max_value;

  fc_argmax #(.DATA_WIDTH(DW), .OUTPUT_NODES(N), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .input_fc(input_fc),
    .busy(busy), .done(done), .class_index(class_index), .max_value(max_value)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  logic [IW+DW-1:0] sb [$];
  logic [IW+DW-1:0] exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        exp_e = sb.pop_front();
        check("class_index", class_index, exp_e[DW +: IW]);
        check("max_value", max_value, exp_e[DW-1:0]);
      end
    end
  end

  // float32 bit pattern of a small non-negative integer
  function automatic logic [31:0] flt(input int i);
    int e;
    logic [31:0] m;
    if (i == 0) return 32'h0;
    e = 0;
    while ((i >> (e + 1)) != 0) e++;
    m = 32'(i - (1 << e)) << (23 - e);
    return (32'(127 + e) << 23) | m;
  endfunction

  function automatic logic [DW*N-1:0] fill(input logic [31:0] v);
    logic [DW*N-1:0] r;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = v;
    return r;
  endfunction

  task automatic run_scan(input logic [DW*N-1:0] vec, input logic [IW-1:0] idx,
                          input logic [31:0] val);
    int j, bc;
    input_fc = vec;
    sb.push_back({idx, val});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    j = 1; bc = 0;
    while (!done && j < 200) begin
      if (busy) bc++;
      @(negedge clk);
      j++;
    end
    check("done_seen", done, 1'b1);
    check("latency", j - 1, N - 1);
    check("busy_cycles", bc, N - 1);
    check("busy_at_done", busy, 1'b0);
  endtask

  logic [DW*N-1:0] v, vb;
  int j, ndone, t1, t2, bad;

  initial begin
    // Reset state
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_class", class_index, '0);
    check("rst_max", max_value, '0);
    @(negedge clk) reset = 1'b1;

    // Ascending ramp
    for (int i = 0; i < N; i++) v[DW*i +: DW] = flt(i);
    run_scan(v, 5'd31, 32'h41F80000);

    // All zero, all equal
    run_scan(fill(32'h0), 5'd0, 32'h0);
    run_scan(fill(32'h3F800000), 5'd0, 32'h3F800000);

    // Negative ordering and signed zeros
    v = fill(32'hBF800000);
    v[DW*7 +: DW] = 32'hBF000000;
    run_scan(v, 5'd7, 32'hBF000000);
    v = fill(32'hBF800000);
    v[DW*3 +: DW] = 32'h80000000;
    v[DW*9 +: DW] = 32'h00000000;
    run_scan(v, 5'd9, 32'h00000000);

    // Snapshot isolation and ignored start during busy
    v = fill(32'h3F800000);
    v[DW*5 +: DW] = 32'h40000000;
    vb = fill(32'h3F800000);
    vb[DW*20 +: DW] = 32'h40800000;
    input_fc = v;
    sb.push_back({5'd5, 32'h40000000});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) begin start = 1'b0; input_fc = vb; end
    check("hold_during_scan", class_index, 5'd9);
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    j = 0;
    while (!done && j < 100) begin @(negedge clk); j++; end
    check("snap_done_seen", done, 1'b1);
    repeat (40) @(negedge clk);
    check("snap_idle_after", busy, 1'b0);

    // Asynchronous reset mid-scan
    v = fill(32'h0);
    v[DW*20 +: DW] = 32'h3F800000;
    input_fc = v;
    sb.push_back({5'd20, 32'h3F800000});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_class", class_index, '0);
    check("arst_max", max_value, '0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("arst_no_done_busy", busy, 1'b0);
    v = fill(32'h0);
    v[DW*12 +: DW] = 32'h3F800000;
    run_scan(v, 5'd12, 32'h3F800000);

    // Continuous start: back-to-back scans
    v = fill(32'h3F000000);
    v[DW*2 +: DW] = 32'h40400000;
    vb = fill(32'h0);
    vb[DW*30 +: DW] = 32'h40800000;
    input_fc = v;
    sb.push_back({5'd2, 32'h40400000});
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    ndone = 0; j = 0; bad = 0; t1 = 0; t2 = 0;
    while (ndone < 2 && j < 300) begin
      @(negedge clk);
      j++;
      if (busy == done) bad++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          t1 = j;
          input_fc = vb;
          sb.push_back({5'd30, 32'h40800000});
        end else begin
          t2 = j;
          start = 1'b0;
        end
      end
    end
    check("cont_dones", ndone, 2);
    check("cont_period", t2 - t1, N);
    check("cont_busy_gaps", bad, 0);

    repeat (40) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/fc_argmax.md
# fc_argmax

Sequential classifier stage downstream of the fully-connected activation (ReLU) stage. On a start pulse it captures the flat vector of OUTPUT_NODES IEEE-754 single-precision values and scans them one per cycle. It reports the index and value of the largest element as the network's predicted class. Results are held stable until the next completed scan.

## Interface
- DATA_WIDTH, 32, width of one float32 node value
- OUTPUT_NODES, 32, number of nodes in the vector; must be ≥ 2
- INDEX_WIDTH, 5, width of class_index; must satisfy 2^INDEX_WIDTH ≥ OUTPUT_NODES
- clk  in  1  clock; all registers update on the rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- start  in  1  request a scan; sampled on rising edge
- input_fc  in  DATA_WIDTH*OUTPUT_NODES  node vector; node i is at input_fc[DATA_WIDTH*i +: DATA_WIDTH]
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when a scan completes
- class_index  out  INDEX_WIDTH  index of maximum node from the last completed scan
- max_value  out  DATA_WIDTH  float32 value of that node

## Operation
- States: IDLE, SCAN.
- IDLE with start=1 at an edge:
  - copy input_fc into an internal snapshot register
  - best_idx←0, best_val←node 0, cnt←1
  - go to SCAN; busy←1
- IDLE with start=0: hold.
- SCAN, each edge:
  - compare snapshot node cnt against best_val
  - if strictly greater, best_idx←cnt and best_val←node cnt
  - cnt←cnt+1
- SCAN, edge where cnt = OUTPUT_NODES-1 (after the compare above):
  - class_index←final best_idx; max_value←final best_val
  - done←1; busy←0; state←IDLE
- done is high for exactly one cycle; it is cleared on the following edge unless another scan completes there.
- start while in SCAN is ignored; no queueing.
- Snapshot isolation: changes on input_fc after the capture edge do not affect the running scan.
- class_index and max_value change only on the completing edge; they stay stable during a scan.

Comparison ordering:
- Each value is mapped to an unsigned key:
  - sign bit 0: key = value XOR 0x80000000
  - sign bit 1: key = bitwise NOT value
- Compare keys as unsigned integers.
- Consequences:
  - negatives order correctly
  - -0.0 ranks below +0.0
  - +NaN ranks above +Inf; -NaN ranks below -Inf
  - NaNs are not special-cased
- Ties (equal keys) keep the lower index.

## Timing
- Reset asserted (any time, including mid-scan):
  - state=IDLE, busy=0, done=0, class_index=0, max_value=0, cnt=0, best registers=0
  - an interrupted scan produces no done
- Latency: start sampled at edge k → busy high after k → done high after edge k+OUTPUT_NODES-1 (edge k+31 at default).
- busy falls on the same edge that done rises.
- Back-to-back scans: start is sampled while done is high (state is IDLE), so a new scan begins immediately. Throughput is one result per OUTPUT_NODES cycles.
- Reset release: the first edge after reset deasserts may sample start.

## Test plan
- Ascending ramp, node i = float(i) (node 31 = 0x41F80000), start pulse:
  - done exactly 31 cycles after the start edge
  - class_index=31, max_value=0x41F80000
  - busy high for exactly 31 cycles
- All nodes 0x00000000 (ReLU all-clamped) → class_index=0, max_value=0. Repeat with all nodes 0x3F800000 → class_index=0 (tie keeps lowest).
- All nodes -1.0 (0xBF800000) except node 7 = -0.5 (0xBF000000) → class_index=7, max_value=0xBF000000. Also node 3 = -0.0 (0x80000000), node 9 = +0.0 → class_index=9.
- Start scan with max at node 5, then change input_fc so node 20 is max on the next cycle:
  - result is still class_index=5
  - a second start pulse during busy causes no extra done and no change to the scan
- Pull reset low at cycle 10 of a scan:
  - all outputs 0 immediately, asynchronously
  - no done pulse
  - after release, a new start with max at node 12 → class_index=12
- Hold start high continuously with vector A (max at node 2), then vector B (max at node 30) from the first done cycle:
  - done pulses every 32 cycles
  - results are 2, then 30
  - busy low only during the done cycles
